// File: rtl/address_generator_a.sv
// A-operand row-buffer read-address generator for an ARRAY_N x ARRAY_N
// systolic array; lane i runs i cycles behind lane 0 so data enters diagonally.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   on                  level run request; one pass per assertion
//   base_addr           first address of the pass, latched at start
//   num_rows            active lanes (clamped to ARRAY_N), latched at start
//   address             lane i address at [ADDR_WIDTH*i +: ADDR_WIDTH]
//   enable              per-lane read enable
//   done                (ADDR_GEN_A_DONE_EN only) one-cycle pulse entering DONE
module address_generator_a #(
  parameter int ADDR_WIDTH        = 16,
  parameter int ARRAY_N           = 8,
  parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH*ARRAY_N
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         on,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [$clog2(ARRAY_N):0]     num_rows,
  output logic [CONCAT_ADDR_WIDTH-1:0] address,
  output logic [ARRAY_N-1:0]           enable
`ifdef ADDR_GEN_A_DONE_EN
  ,
  output logic                         done
`endif
);

  localparam int NW = $clog2(ARRAY_N) + 1;
  localparam int TW = $clog2(2*ARRAY_N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [TW-1:0]                t_q, t_d;
  logic [ADDR_WIDTH-1:0]        b_q, b_d;
  logic [NW-1:0]                r_q, r_d;
  logic [CONCAT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ARRAY_N-1:0]           en_q, en_d;
  logic                         done_d;

  logic [NW-1:0]                rows_clamped;
  logic [ARRAY_N-1:0]           lane_en;
  logic [CONCAT_ADDR_WIDTH-1:0] lane_addr;
  logic                         last;

  assign rows_clamped = (num_rows > NW'(ARRAY_N)) ? NW'(ARRAY_N)
                                                  : num_rows;

  // Final RUN cycle: lane R-1 issues its last address at t = R+ARRAY_N-2.
  assign last = (int'(t_q) == int'(r_q) + ARRAY_N - 2);

  always_comb begin
    lane_en   = '0;
    lane_addr = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      lane_en[i] = (int'(r_q) > i) &&
                   (int'(t_q) >= i) &&
                   (int'(t_q) <= i + ARRAY_N - 1);
      if (lane_en[i])
        lane_addr[ADDR_WIDTH*i +: ADDR_WIDTH] =
          b_q + ADDR_WIDTH'(t_q) - ADDR_WIDTH'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    b_d     = b_q;
    r_d     = r_q;
    addr_d  = '0;
    en_d    = '0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (on) begin
          b_d     = base_addr;
          r_d     = rows_clamped;
          t_d     = '0;
          done_d  = (rows_clamped == '0);
          state_d = (rows_clamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!on) begin
          state_d = IDLE;
        end else begin
          en_d   = lane_en;
          addr_d = lane_addr;
          t_d    = t_q + 1'b1;
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!on) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      addr_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      b_q     <= b_d;
      r_q     <= r_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
    end
  end

  assign address = addr_q;
  assign enable  = en_q;

`ifdef ADDR_GEN_A_DONE_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_d;
  end

  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_d;
`endif

endmodule

// File: tb/tb_address_generator_a.sv
// Scoreboard bench for address_generator_a: a pass-level reference model
// predicts each cycle's outputs; a monitor pops and compares on negedge.
module tb_address_generator_a;

  localparam int AW = 16;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          on;
  logic [AW-1:0] base_addr;
  logic [3:0]    num_rows;
  logic [AW*N-1:0] address;
  logic [N-1:0]  enable;
`ifdef ADDR_GEN_A_DONE_EN
  logic          done;
`endif

  address_generator_a #(.ADDR_WIDTH(AW), .ARRAY_N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .on        (on),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .address   (address),
    .enable    (enable)
`ifdef ADDR_GEN_A_DONE_EN
    ,
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    en;
    logic [AW*N-1:0] addr;
    logic            dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Pass-level model: a pass is "busy" for R+N-1 output cycles, during
  // which lane i replays B, B+1, ... B+N-1 starting i cycles after lane 0.
  bit          m_busy = 0;
  bit          m_wait = 0;
  int          m_k    = 0;
  int          m_b    = 0;
  int          m_r    = 0;

  task automatic model(input logic r, input logic o,
                       input logic [AW-1:0] b, input logic [3:0] n);
    exp_t e;
    e.en   = '0;
    e.addr = '0;
    e.dn   = 1'b0;
    if (r) begin
      m_busy = 0;
      m_wait = 0;
      m_b    = 0;
      m_r    = 0;
    end else if (m_busy) begin
      if (!o) begin
        m_busy = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (i < m_r && m_k >= i && m_k - i < N) begin
            e.en[i] = 1'b1;
            e.addr[AW*i +: AW] = AW'(m_b + m_k - i);
          end
        end
        if (m_k == m_r + N - 2) begin
          m_busy = 0;
          m_wait = 1;
          e.dn   = 1'b1;
        end
        m_k++;
      end
    end else if (m_wait) begin
      if (!o) m_wait = 0;
    end else if (o) begin
      m_b = int'(b);
      m_r = (int'(n) > N) ? N : int'(n);
      m_k = 0;
      if (m_r == 0) begin
        m_wait = 1;
        e.dn   = 1'b1;
      end else begin
        m_busy = 1;
      end
    end
    q.push_back(e);
  endtask

  task automatic step(input logic r, input logic o,
                      input logic [AW-1:0] b, input logic [3:0] n);
    reset     = r;
    on        = o;
    base_addr = b;
    num_rows  = n;
    @(posedge clk);
    model(r, o, b, n);
    #1;
  endtask

  task automatic hold(input int cycles);
    for (int c = 0; c < cycles; c++)
      step(1'b0, 1'b1, AW'($urandom), 4'($urandom));
  endtask

  task automatic drop(input int cycles);
    for (int c = 0; c < cycles; c++)
      step(1'b0, 1'b0, AW'($urandom), 4'($urandom));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (enable !== e.en) begin
          errors++;
          $display("FAIL enable @%0t: got %h want %h", $time, enable, e.en);
        end
        checks++;
        if (address !== e.addr) begin
          errors++;
          $display("FAIL address @%0t: got %h want %h",
                   $time, address, e.addr);
        end
`ifdef ADDR_GEN_A_DONE_EN
        checks++;
        if (done !== e.dn) begin
          errors++;
          $display("FAIL done @%0t: got %b want %b", $time, done, e.dn);
        end
`endif
      end
    end
  end

  initial begin : stim
    reset     = 1'b1;
    on        = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    repeat (3) step(1'b1, 1'b0, '0, '0);
    drop(2);
    // full 8-row pass from 0, then on held high well past the end
    step(1'b0, 1'b1, 16'h0000, 4'd8);
    hold(36);
    // one-cycle drop then a 3-row pass at 0x0100
    drop(1);
    step(1'b0, 1'b1, 16'h0100, 4'd3);
    hold(12);
    drop(1);
    // wrap-around on a single lane
    step(1'b0, 1'b1, 16'hFFFE, 4'd1);
    hold(10);
    drop(1);
    // zero rows: straight to DONE
    step(1'b0, 1'b1, 16'h4444, 4'd0);
    hold(3);
    drop(2);
    // clamp num_rows above ARRAY_N
    step(1'b0, 1'b1, 16'h0010, 4'd15);
    hold(16);
    drop(1);
    // abort at cycle 4, then immediate restart with new base
    step(1'b0, 1'b1, 16'h1234, 4'd8);
    hold(4);
    drop(1);
    step(1'b0, 1'b1, 16'h5555, 4'd8);
    hold(5);
    // reset mid-pass
    step(1'b1, 1'b1, 16'h0000, 4'd8);
    drop(2);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) != 0),
           AW'($urandom), 4'($urandom));
    end
    drop(3);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
